// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline freeze/flush sequencer.
//   - SRAM wait FSM state encodings (2-bit; 2 and 3 are illegal)
//   - per-stage control bundle driven by the sequencer
//   - NOP control word for the ID/EXE register (all enables zero)
package pipe_stall_ctrl_pkg;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_BUSY = 2'd1;

  // Per-stage register controls produced each cycle
  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic freeze_back;
    logic bubble_id_exe;
    logic flush_if_id;
    logic sram_start;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_IDLE = '0;

  // ID/EXE control word; a bubble loads ID_EXE_NOP
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } id_exe_ctrl_t;

  localparam id_exe_ctrl_t ID_EXE_NOP = '0;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear, wins over inc
//   inc  : count enable
//   q    : count, holds at all-ones
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central freeze/flush sequencer for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
// Combines hazard, EXE branch_taken and the MEM-stage SRAM handshake into
// per-stage register controls; owns the SRAM wait FSM with timeout and the
// stall/flush performance counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   hazard                   ID depends on an in-flight EXE/MEM destination
//   branch_taken             EXE resolves a taken branch
//   mem_req, sram_ready      MEM access request / SRAM completion pulse
//   cnt_clr                  clear both performance counters
//   freeze_pc, freeze_if_id  hold PC / IF/ID
//   freeze_back              hold ID/EXE, EXE/MEM, MEM/WB
//   bubble_id_exe            load NOP into ID/EXE
//   flush_if_id              load NOP into IF/ID
//   sram_start               one-cycle SRAM launch pulse
//   mem_err                  sticky SRAM timeout flag
//   stall_cycles             saturating count of PC-held cycles
//   flush_count              saturating count of branch flushes
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_back,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             sram_start,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [1:0]      st;
  logic [1:0]      st_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_nxt;
  logic            err_set;
  logic            mem_frz;
  logic            start;
  stage_ctrl_t     ctrl;

  // State, timeout counter and sticky error register
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_RUN;
      to_cnt  <= '0;
      mem_err <= 1'b0;
    end else begin
      st     <= st_nxt;
      to_cnt <= to_nxt;
      if (err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

  // SRAM wait FSM: next state, timeout and memory freeze
  always_comb begin
    st_nxt  = st;
    to_nxt  = to_cnt;
    err_set = 1'b0;
    mem_frz = 1'b0;
    start   = 1'b0;
    case (st)
      ST_RUN: begin
        // A ready pulse seen here is stale and deliberately ignored
        if (mem_req) begin
          start   = 1'b1;
          mem_frz = 1'b1;
          st_nxt  = ST_MEM_BUSY;
          to_nxt  = '0;
        end
      end
      ST_MEM_BUSY: begin
        // Ready is checked first so it wins on the final timeout cycle
        if (sram_ready) begin
          st_nxt = ST_RUN;
        end else if (to_cnt == TO_LAST) begin
          err_set = 1'b1;
          st_nxt  = ST_RUN;
        end else begin
          mem_frz = 1'b1;
          to_nxt  = to_cnt + TO_W'(1);
        end
      end
      default: begin
        st_nxt = ST_RUN;
      end
    endcase
  end

  // Priority mux: memory freeze > branch flush > hazard stall.
  // While the back end is frozen, branch/hazard sources are held and retried later.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!rst) begin
      if (mem_frz) begin
        ctrl.freeze_pc    = 1'b1;
        ctrl.freeze_if_id = 1'b1;
        ctrl.freeze_back  = 1'b1;
        ctrl.sram_start   = start;
      end else if (branch_taken) begin
        ctrl.flush_if_id   = 1'b1;
        ctrl.bubble_id_exe = 1'b1;
      end else if (hazard) begin
        ctrl.freeze_pc     = 1'b1;
        ctrl.freeze_if_id  = 1'b1;
        ctrl.bubble_id_exe = 1'b1;
      end
    end
  end

  assign freeze_pc     = ctrl.freeze_pc;
  assign freeze_if_id  = ctrl.freeze_if_id;
  assign freeze_back   = ctrl.freeze_back;
  assign bubble_id_exe = ctrl.bubble_id_exe;
  assign flush_if_id   = ctrl.flush_if_id;
  assign sram_start    = ctrl.sram_start;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (ctrl.freeze_pc),
    .q   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (ctrl.flush_if_id),
    .q   (flush_count)
  );

endmodule
